// File: rtl/spi_slave_if_if.sv
// Bundle of the SPI pins and the RAM-side word/byte handshake used by spi_slave_if.
interface spi_slave_if_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
);
  logic            MOSI;
  logic            SS_n;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  // The SPI slave block itself
  modport slave (
    input  MOSI, SS_n, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  // Whatever drives the slave: SPI master plus the RAM's read port
  modport master (
    output MOSI, SS_n, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises MOSI frames into
// RX_W-bit words and serialises the RAM's TX_W-bit read data onto MISO.
// Everything runs on the system clock; SCK is not used as a clock.
module spi_slave_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  localparam int CW = $clog2(RX_W + 2);
  localparam int TW = $clog2(TX_W + 2);

  // Bit counter: 0..RX_W-1 while receiving, RX_W means "word complete, deliver",
  // RX_W+1 means "word delivered, holding until SS_n rises".
  localparam logic [CW-1:0] RX_LAST = CW'(RX_W);
  localparam logic [CW-1:0] RX_DONE = CW'(RX_W + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Shift-out counter: loaded with TX_W+1; values above 1 drive one bit each,
  // 1 is the trailing cycle that returns MISO to 0 and retires the read address.
  localparam logic [TW-1:0] TX_LOAD = TW'(TX_W + 1);
  localparam logic [TW-1:0] TX_ONE  = TW'(1);
  localparam logic [TW-1:0] TX_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RX_W-1:0] rx_sh_q, rx_sh_d;
  logic [RX_W-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_seen_q, rd_seen_d;
  logic [TX_W-1:0] tx_sh_q, tx_sh_d;
  logic [TW-1:0]   tx_cnt_q, tx_cnt_d;
  logic            tx_done_q, tx_done_d;
  logic            miso_q, miso_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: frame start on SS_n low, frame type from the command bit, abort on SS_n high
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)       state_d = IDLE;
        else if (!bus.MOSI) state_d = WRITE;
        else if (rd_seen_q) state_d = READ_DATA;
        else                state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: receive shifter, word delivery, read-byte shift-out
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_done_d  = tx_done_q;
    miso_d     = 1'b0;
    case (state_q)
      WRITE, READ_ADD, READ_DATA: begin
        if (bit_cnt_q < RX_LAST) begin
          rx_sh_d   = {rx_sh_q[RX_W-2:0], bus.MOSI};
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else if (bit_cnt_q == RX_LAST) begin
          // A completed word is delivered even if SS_n rises on this same edge
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = RX_DONE;
          if (state_q == READ_ADD) rd_seen_d = 1'b1;
        end else if (state_q == READ_DATA && !bus.SS_n) begin
          // tx_valid is only honoured once the dummy word is in, and once per frame
          if (tx_cnt_q == TX_ZERO) begin
            if (!tx_done_q && bus.tx_valid) begin
              tx_sh_d  = bus.tx_data;
              tx_cnt_d = TX_LOAD;
            end
          end else if (tx_cnt_q == TX_ONE) begin
            rd_seen_d = 1'b0;
            tx_cnt_d  = TX_ZERO;
            tx_done_d = 1'b1;
          end else begin
            miso_d   = tx_sh_q[TX_W-1];
            tx_sh_d  = {tx_sh_q[TX_W-2:0], 1'b0};
            tx_cnt_d = tx_cnt_q - TX_ONE;
          end
        end
        if (bus.SS_n) begin
          bit_cnt_d = '0;
          tx_cnt_d  = TX_ZERO;
          tx_done_d = 1'b0;
          miso_d    = 1'b0;
        end
      end
      default: begin
        bit_cnt_d = '0;
        tx_cnt_d  = TX_ZERO;
        tx_done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears every output and discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= TX_ZERO;
      tx_done_q  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_seen_q  <= rd_seen_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_done_q  <= tx_done_d;
      miso_q     <= miso_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed frames from the test plan
// followed by random frames, all checked against a frame-level reference model.
module tb_spi_slave_if;
  localparam int RX_W = 10;
  localparam int TX_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if_if #(.RX_W(RX_W), .TX_W(TX_W)) bus ();

  spi_slave_if #(.RX_W(RX_W), .TX_W(TX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: has a read address been taken, and last delivered word
  bit              m_seen;
  logic [RX_W-1:0] m_last_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outside a delivery or shift-out slot: no strobe, MISO low, rx_data held
  task automatic chk_quiet(input string tag);
    chk({tag, "_rxv"},  {31'd0, bus.rx_valid}, 32'd0);
    chk({tag, "_miso"}, {31'd0, bus.MISO},     32'd0);
    chk({tag, "_rxd"},  {22'd0, bus.rx_data},  {22'd0, m_last_rx});
  endtask

  // One SPI frame. nbits<RX_W aborts after that many data bits. ss_hi_at_done
  // raises SS_n on the delivery edge. rst_at>=0 pulses reset on that shift-out slot.
  task automatic run_frame(input bit cmd, input logic [RX_W-1:0] word, input int nbits,
                           input bit ss_hi_at_done, input bit do_tx,
                           input logic [TX_W-1:0] txb, input int rst_at, input int gap);
    bit   is_rd_data;
    logic exp_miso;
    is_rd_data = cmd && m_seen;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    chk_quiet("ss_fall");
    bus.MOSI = cmd;
    tick();
    chk_quiet("cmd");
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI     = word[RX_W-1-i];
      bus.tx_valid = is_rd_data ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.tx_data  = 8'($urandom);
      tick();
      chk_quiet("rxbit");
    end
    bus.tx_valid = 1'b0;
    if (nbits < RX_W) begin
      bus.SS_n = 1'b1;
      tick();
      chk_quiet("abort");
      for (int g = 1; g < gap; g++) begin
        tick();
        chk_quiet("abort_gap");
      end
      return;
    end
    bus.MOSI = 1'($urandom);
    if (ss_hi_at_done) bus.SS_n = 1'b1;
    tick();
    m_last_rx = word;
    if (cmd && !m_seen) m_seen = 1'b1;
    chk("rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("rx_data",  {22'd0, bus.rx_data},  {22'd0, word});
    chk("miso_at_valid", {31'd0, bus.MISO}, 32'd0);
    if (ss_hi_at_done) begin
      tick();
      chk_quiet("done_abort");
      for (int g = 1; g < gap; g++) begin
        tick();
        chk_quiet("done_gap");
      end
      return;
    end
    bus.tx_valid = do_tx;
    bus.tx_data  = txb;
    tick();
    chk_quiet("tx_load");
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    for (int i = 0; i <= TX_W; i++) begin
      if (rst_at == i) rst = 1'b1;
      bus.MOSI = 1'($urandom);
      tick();
      rst = 1'b0;
      if (rst_at == i) begin
        m_seen    = 1'b0;
        m_last_rx = '0;
        chk_quiet("after_rst");
        break;
      end
      exp_miso = (is_rd_data && do_tx && i < TX_W) ? txb[TX_W-1-i] : 1'b0;
      chk("miso", {31'd0, bus.MISO}, {31'd0, exp_miso});
      chk("rxv_shift", {31'd0, bus.rx_valid}, 32'd0);
    end
    if (is_rd_data && do_tx && rst_at < 0) m_seen = 1'b0;
    bus.SS_n = 1'b1;
    tick();
    chk_quiet("ss_rise");
    for (int g = 1; g < gap; g++) begin
      tick();
      chk_quiet("gap");
    end
  endtask

  initial begin
    int nb;
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    m_seen       = 1'b0;
    m_last_rx    = '0;
    tick();
    tick();
    chk("rst_miso", {31'd0, bus.MISO},     32'd0);
    chk("rst_rxv",  {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_rxd",  {22'd0, bus.rx_data},  32'd0);
    rst = 1'b0;
    tick();
    chk_quiet("post_rst");

    // Write address then write data, back to back with a one-cycle gap
    run_frame(1'b0, 10'h0A5, RX_W, 1'b0, 1'b0, 8'h00, -1, 1);
    run_frame(1'b0, 10'h1F0, RX_W, 1'b0, 1'b0, 8'h00, -1, 1);
    // Read address (RAM answer ignored), then read data with 0xC3
    run_frame(1'b1, 10'h203, RX_W, 1'b0, 1'b1, 8'h5A, -1, 2);
    run_frame(1'b1, 10'h300, RX_W, 1'b0, 1'b1, 8'hC3, -1, 2);
    // Aborted frame after 5 bits, then a full frame
    run_frame(1'b0, 10'h3FF, 5, 1'b0, 1'b0, 8'h00, -1, 1);
    run_frame(1'b0, 10'h155, RX_W, 1'b0, 1'b0, 8'h00, -1, 1);
    // SS_n rising on the delivery edge still delivers; read address stays taken
    run_frame(1'b1, 10'h2AA, RX_W, 1'b1, 1'b0, 8'h00, -1, 1);
    // Reset in the middle of a read-data shift-out, then command 1 is a read address again
    run_frame(1'b1, 10'h300, RX_W, 1'b0, 1'b1, 8'hA5, 3, 1);
    run_frame(1'b1, 10'h211, RX_W, 1'b0, 1'b1, 8'hFF, -1, 1);
    run_frame(1'b1, 10'h300, RX_W, 1'b0, 1'b1, 8'h81, -1, 1);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, RX_W - 1)) : RX_W;
      run_frame(1'($urandom), 10'($urandom), nb,
                ($urandom_range(0, 5) == 0), 1'($urandom),
                8'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TX_W - 1)) : -1,
                int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
